sfifo_burst_drain: RTL and testbench

- Read-side controller for the threshold FIFO (sfifothresh/sfifo, built with OPT_ASYNC_READ=1).
- Decides when to drain the FIFO and emits packets on an AXI-stream master.
- A full burst starts once the fill reaches the programmed burst length.
- A flush timer drains a partial burst when data has waited too long, so low-rate traffic is never stranded.

---
 rtl/sfifo_drain_pkg.sv | 30 +++
 rtl/sfifo_burst_drain_if.sv | 29 ++
 rtl/drain_flush_timer.sv | 32 +++
 rtl/sfifo_burst_drain.sv | 131 +++++++++++++
 tb/tb_sfifo_burst_drain.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfifo_drain_pkg.sv
// Shared types and helpers for the burst-drain read controller.
//   drain_state_e : controller state (idle / burst in progress)
//   Rst*          : values the controller registers take on reset
//   clamp_len     : maps a requested burst length into 1..(1<<lgflen)
package sfifo_drain_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } drain_state_e;

    localparam int unsigned RstThreshold = 1;
    localparam logic        RstTvalid    = 1'b0;
    localparam logic        RstTlast     = 1'b0;

    // A zero-length request still moves data one word at a time; anything
    // beyond the FIFO depth could never be satisfied, so cap it at the depth.
    function automatic int unsigned clamp_len(int unsigned burst_len, int unsigned lgflen);
        int unsigned flen;
        flen = 32'd1 << lgflen;
        if (burst_len == 0) begin
            return 1;
        end
        if (burst_len > flen) begin
            return flen;
        end
        return burst_len;
    endfunction

endpackage

// File: rtl/sfifo_burst_drain_if.sv
// AXI-stream style output bundle of the burst-drain controller.
//   M_AXIS_TVALID : beat valid       (master -> slave)
//   M_AXIS_TREADY : beat accepted    (slave  -> master)
//   M_AXIS_TDATA  : beat data        (master -> slave)
//   M_AXIS_TLAST  : last beat of burst (master -> slave)
interface sfifo_burst_drain_if #(
    parameter int unsigned BW = 8
) ();

    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic [BW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TLAST;

    modport master (
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );

endinterface

// File: rtl/drain_flush_timer.sv
// Saturating wait timer for partial-burst flushing.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_clear        : zero the timer (has priority over i_enable)
//   i_enable       : count one cycle, holding at all-ones
//   i_timeout      : flush threshold; zero means never expire
//   o_expired      : timer has reached a non-zero i_timeout
module drain_flush_timer #(
    parameter int unsigned LGTIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [LGTIMEOUT-1:0] i_timeout,
    output logic                 o_expired
);

    logic [LGTIMEOUT-1:0] timer_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer_q <= '0;
        end else if (i_clear) begin
            timer_q <= '0;
        end else if (i_enable && (timer_q != '1)) begin
            timer_q <= timer_q + LGTIMEOUT'(1);
        end
    end

    assign o_expired = (i_timeout != '0) && (timer_q >= i_timeout);

endmodule

// File: rtl/sfifo_burst_drain.sv
// Read-side controller for a threshold FIFO with combinational read data.
// Starts a burst once the fill reaches the (clamped) burst length, or flushes
// whatever is waiting after i_timeout idle cycles, and streams it out.
//   i_clk, i_reset    : clock, asynchronous active-high reset
//   i_burst_len       : requested words per burst (0 -> 1, >FLEN -> FLEN)
//   i_timeout         : idle cycles before a partial flush, 0 disables
//   i_fifo_fill/empty : FIFO occupancy
//   i_fifo_data       : FIFO head word, valid in the same cycle as o_fifo_rd
//   o_fifo_rd         : FIFO pop strobe
//   o_threshold       : burst length in force, drives the FIFO threshold
//   m_axis            : stream output (valid/ready/data/last)
//   o_busy            : burst in progress or a beat still pending
module sfifo_burst_drain
    import sfifo_drain_pkg::*;
#(
    parameter int unsigned BW        = 8,
    parameter int unsigned LGFLEN    = 4,
    parameter int unsigned LGTIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [LGFLEN:0]      i_burst_len,
    input  logic [LGTIMEOUT-1:0] i_timeout,
    input  logic [LGFLEN:0]      i_fifo_fill,
    input  logic                 i_fifo_empty,
    input  logic [BW-1:0]        i_fifo_data,
    output logic                 o_fifo_rd,
    output logic [LGFLEN:0]      o_threshold,
    sfifo_burst_drain_if.master  m_axis,
    output logic                 o_busy
);

    typedef logic [LGFLEN:0] len_t;

    drain_state_e  state_q, state_d;
    len_t          count_q, count_d;
    len_t          threshold_q, threshold_d;
    len_t          len;
    logic          load;
    logic          start_burst;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_expired;
    logic          tvalid_q, tlast_q;
    logic [BW-1:0] tdata_q;

    assign len = len_t'(clamp_len(32'(i_burst_len), LGFLEN));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        threshold_d = threshold_q;
        start_burst = 1'b0;
        // A pending beat that is not being accepted blocks the next pop.
        load = (state_q == StBurst) && !i_fifo_empty && (!tvalid_q || m_axis.M_AXIS_TREADY);

        unique case (state_q)
            StIdle: begin
                threshold_d = len;
                if (i_fifo_fill >= threshold_q) begin
                    state_d     = StBurst;
                    count_d     = threshold_q;
                    start_burst = 1'b1;
                end else if (timer_expired && (i_fifo_fill != '0)) begin
                    // Snapshot the fill: only this block reads, so all of it is there.
                    state_d     = StBurst;
                    count_d     = i_fifo_fill;
                    start_burst = 1'b1;
                end
            end
            StBurst: begin
                if (load) begin
                    count_d = count_q - len_t'(1);
                    if (count_q == len_t'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign timer_clear = (state_q == StBurst) || (i_fifo_fill == '0) || start_burst;
    assign timer_en    = (state_q == StIdle);

    drain_flush_timer #(
        .LGTIMEOUT(LGTIMEOUT)
    ) u_flush_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (timer_clear),
        .i_enable (timer_en),
        .i_timeout(i_timeout),
        .o_expired(timer_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            threshold_q <= len_t'(RstThreshold);
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            threshold_q <= threshold_d;
        end
    end

    // Stream output register: holds its beat until accepted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tvalid_q <= RstTvalid;
            tlast_q  <= RstTlast;
            tdata_q  <= '0;
        end else if (load) begin
            tvalid_q <= 1'b1;
            tlast_q  <= (count_q == len_t'(1));
            tdata_q  <= i_fifo_data;
        end else if (m_axis.M_AXIS_TREADY) begin
            tvalid_q <= 1'b0;
        end
    end

    assign o_fifo_rd            = load;
    assign o_threshold          = threshold_q;
    assign o_busy               = (state_q == StBurst) || tvalid_q;
    assign m_axis.M_AXIS_TVALID = tvalid_q;
    assign m_axis.M_AXIS_TDATA  = tdata_q;
    assign m_axis.M_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_sfifo_burst_drain.sv
// Self-checking bench for sfifo_burst_drain: a behavioural 16-deep FIFO with
// combinational read feeds the DUT, a monitor records accepted beats, and
// each test compares them with the expected words and packet boundaries.
module tb_sfifo_burst_drain;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [4:0]  burst_len = 5'd1;
    logic [15:0] timeout = 16'd0;
    logic [4:0]  i_fifo_fill;
    logic        i_fifo_empty;
    logic [7:0]  i_fifo_data;
    logic        o_fifo_rd;
    logic [4:0]  o_threshold;
    logic        o_busy;

    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    bit          rand_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int underflow = 0;

    logic [8:0] beats[$];     // {tlast, tdata} of each accepted beat
    int         beat_cyc[$];  // cycle number of each accepted beat

    // FIFO model
    logic [7:0] fmem[16];
    logic [3:0] fwp = 4'd0;
    logic [3:0] frp = 4'd0;
    logic [4:0] fcnt = 5'd0;

    sfifo_burst_drain_if #(.BW(8)) axis ();

    sfifo_burst_drain #(
        .BW       (8),
        .LGFLEN   (4),
        .LGTIMEOUT(16)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_burst_len (burst_len),
        .i_timeout   (timeout),
        .i_fifo_fill (i_fifo_fill),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_data (i_fifo_data),
        .o_fifo_rd   (o_fifo_rd),
        .o_threshold (o_threshold),
        .m_axis      (axis),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    assign i_fifo_fill  = fcnt;
    assign i_fifo_empty = (fcnt == 5'd0);
    assign i_fifo_data  = fmem[frp];

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            fmem[fwp] <= wr_data;
            fwp       <= fwp + 4'd1;
        end
        if (o_fifo_rd) begin
            frp    <= frp + 4'd1;
            rd_cnt <= rd_cnt + 1;
            if (fcnt == 5'd0) underflow <= underflow + 1;
        end
        fcnt <= fcnt + {4'd0, wr_en} - {4'd0, o_fifo_rd};
        if (!i_reset && axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
            beats.push_back({axis.M_AXIS_TLAST, axis.M_AXIS_TDATA});
            beat_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge i_clk);
        if (rand_ready) axis.M_AXIS_TREADY = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [7:0] d);
        int guard = 0;
        while (fcnt == 5'd16 && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500) begin
            errors++;
            checks++;
            $display("FAIL push_full_timeout: fifo fill %0d required below 16", fcnt);
        end
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_beats(input int base, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (beats.size() >= base + n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (beats.size() >= base + n) ok = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (axis.M_AXIS_TVALID !== 1'b0) begin errors++;
            $display("FAIL rst_tvalid: got %b want 0", axis.M_AXIS_TVALID); end
        checks++; if (axis.M_AXIS_TLAST !== 1'b0) begin errors++;
            $display("FAIL rst_tlast: got %b want 0", axis.M_AXIS_TLAST); end
        checks++; if (axis.M_AXIS_TDATA !== 8'h00) begin errors++;
            $display("FAIL rst_tdata: got %h want 00", axis.M_AXIS_TDATA); end
        checks++; if (o_threshold !== 5'd1) begin errors++;
            $display("FAIL rst_threshold: got %0d want 1", o_threshold); end
        checks++; if (o_busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b want 0", o_busy); end
        checks++; if (o_fifo_rd !== 1'b0) begin errors++;
            $display("FAIL rst_rd: got %b want 0", o_fifo_rd); end
        i_reset = 1'b0;
        axis.M_AXIS_TREADY = 1'b1;
        repeat (3) tick();
        checks++; if (o_busy !== 1'b0 || beats.size() != 0) begin errors++;
            $display("FAIL rst_idle: busy %b beats %0d want 0/0", o_busy, beats.size()); end
    endtask

    task automatic test_full_burst();
        logic [7:0] a[4];
        int base;
        bit ok;
        burst_len = 5'd4;
        timeout   = 16'd0;
        axis.M_AXIS_TREADY = 1'b1;
        repeat (3) tick();
        checks++; if (o_threshold !== 5'd4) begin errors++;
            $display("FAIL full_threshold: got %0d want 4", o_threshold); end
        base = beats.size();
        for (int i = 0; i < 4; i++) a[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) push(a[i]);
        // Fill reaches 4 at this edge: BURST next edge, first beat the edge after.
        checks++; if (axis.M_AXIS_TVALID !== 1'b0) begin errors++;
            $display("FAIL full_lat0: tvalid %b want 0", axis.M_AXIS_TVALID); end
        tick();
        checks++; if (axis.M_AXIS_TVALID !== 1'b0 || o_busy !== 1'b1) begin errors++;
            $display("FAIL full_lat1: tvalid %b busy %b want 0/1", axis.M_AXIS_TVALID, o_busy); end
        tick();
        checks++; if (axis.M_AXIS_TVALID !== 1'b1 || axis.M_AXIS_TDATA !== a[0]) begin errors++;
            $display("FAIL full_lat2: tvalid %b data %h want 1/%h", axis.M_AXIS_TVALID,
                     axis.M_AXIS_TDATA, a[0]); end
        wait_beats(base, 4, 20, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL full_timeout: beats %0d want %0d", beats.size() - base, 4); end
        checks++; if (o_busy !== 1'b0) begin errors++;
            $display("FAIL full_busy_drop: got %b want 0", o_busy); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beats[base+i] !== {(i == 3), a[i]}) begin errors++;
                    $display("FAIL full_beat%0d: got %h want %h", i, beats[base+i],
                             {(i == 3), a[i]}); end
                if (i > 0) begin
                    checks++;
                    if (beat_cyc[base+i] != beat_cyc[base+i-1] + 1) begin errors++;
                        $display("FAIL full_gap%0d: got %0d want 1", i,
                                 beat_cyc[base+i] - beat_cyc[base+i-1]); end
                end
            end
        end
        checks++; if (fcnt !== 5'd0) begin errors++;
            $display("FAIL full_fifo_empty: fill %0d want 0", fcnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] b[3];
        logic [7:0] hd;
        logic       hl;
        int base, rd0, rd1;
        bit ok;
        burst_len = 5'd3;
        repeat (3) tick();
        base = beats.size();
        rd0  = rd_cnt;
        for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) push(b[i]);
        wait_beats(base, 1, 20, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL bp_timeout1: beats %0d want 1", beats.size() - base); end
        axis.M_AXIS_TREADY = 1'b0;
        hd  = axis.M_AXIS_TDATA;
        hl  = axis.M_AXIS_TLAST;
        rd1 = rd_cnt;
        checks++; if (hd !== b[1] || hl !== 1'b0) begin errors++;
            $display("FAIL bp_held_beat: got %h/%b want %h/0", hd, hl, b[1]); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (axis.M_AXIS_TVALID !== 1'b1 || axis.M_AXIS_TDATA !== hd ||
                axis.M_AXIS_TLAST !== hl) begin errors++;
                $display("FAIL bp_stable%0d: got %b/%h/%b want 1/%h/%b", c,
                         axis.M_AXIS_TVALID, axis.M_AXIS_TDATA, axis.M_AXIS_TLAST, hd, hl); end
        end
        checks++; if (rd_cnt != rd1) begin errors++;
            $display("FAIL bp_no_reads: got %0d extra reads want 0", rd_cnt - rd1); end
        axis.M_AXIS_TREADY = 1'b1;
        wait_beats(base, 3, 20, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL bp_timeout3: beats %0d want 3", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[base+i] !== {(i == 2), b[i]}) begin errors++;
                    $display("FAIL bp_beat%0d: got %h want %h", i, beats[base+i],
                             {(i == 2), b[i]}); end
            end
        end
        checks++; if (rd_cnt - rd0 != 3) begin errors++;
            $display("FAIL bp_read_count: got %0d want 3", rd_cnt - rd0); end
    endtask

    task automatic test_flush();
        logic [7:0] w[5];
        int base;
        bit ok;
        burst_len = 5'd8;
        timeout   = 16'd10;
        repeat (3) tick();
        checks++; if (o_threshold !== 5'd8) begin errors++;
            $display("FAIL flush_threshold: got %0d want 8", o_threshold); end
        base = beats.size();
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) push(w[i]);
        // Timer counts from the edge after the first write; decision when it reads 10.
        repeat (8) tick();
        checks++; if (o_busy !== 1'b0) begin errors++;
            $display("FAIL flush_early: busy %b want 0", o_busy); end
        tick();
        checks++; if (o_busy !== 1'b1) begin errors++;
            $display("FAIL flush_start: busy %b want 1", o_busy); end
        wait_beats(base, 3, 20, ok);
        repeat (5) tick();
        checks++; if (beats.size() != base + 3) begin errors++;
            $display("FAIL flush_count: got %0d beats want 3", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[base+i] !== {(i == 2), w[i]}) begin errors++;
                    $display("FAIL flush_beat%0d: got %h want %h", i, beats[base+i],
                             {(i == 2), w[i]}); end
            end
        end
        timeout = 16'd0;
        repeat (2) tick();
        base = beats.size();
        push(w[3]);
        push(w[4]);
        repeat (60) tick();
        checks++; if (beats.size() != base || o_busy !== 1'b0) begin errors++;
            $display("FAIL flush_disabled: beats %0d busy %b want 0/0", beats.size() - base,
                     o_busy); end
        burst_len = 5'd2;
        wait_beats(base, 2, 20, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL flush_drain_timeout: beats %0d want 2", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (beats[base+i] !== {(i == 1), w[3+i]}) begin errors++;
                    $display("FAIL flush_drain%0d: got %h want %h", i, beats[base+i],
                             {(i == 1), w[3+i]}); end
            end
        end
    endtask

    task automatic test_clamp();
        logic [7:0] c[16];
        int base;
        bit ok;
        burst_len = 5'd0;
        repeat (3) tick();
        checks++; if (o_threshold !== 5'd1) begin errors++;
            $display("FAIL clamp_zero_threshold: got %0d want 1", o_threshold); end
        base = beats.size();
        for (int i = 0; i < 3; i++) c[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) push(c[i]);
        wait_beats(base, 3, 30, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL clamp_zero_timeout: beats %0d want 3", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beats[base+i] !== {1'b1, c[i]}) begin errors++;
                    $display("FAIL clamp_zero_beat%0d: got %h want %h", i, beats[base+i],
                             {1'b1, c[i]}); end
            end
        end
        burst_len = 5'd31;
        repeat (3) tick();
        checks++; if (o_threshold !== 5'd16) begin errors++;
            $display("FAIL clamp_max_threshold: got %0d want 16", o_threshold); end
        base = beats.size();
        for (int i = 0; i < 16; i++) c[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) push(c[i]);
        wait_beats(base, 16, 60, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL clamp_max_timeout: beats %0d want 16", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (beats[base+i] !== {(i == 15), c[i]}) begin errors++;
                    $display("FAIL clamp_max_beat%0d: got %h want %h", i, beats[base+i],
                             {(i == 15), c[i]}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[8];
        int base, gap;
        bit ok;
        burst_len = 5'd16;
        repeat (3) tick();
        base = beats.size();
        for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) push(d[i]);
        burst_len = 5'd2;
        wait_beats(base, 8, 40, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL b2b_timeout: beats %0d want 8", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (beats[base+i] !== {(i % 2 == 1), d[i]}) begin errors++;
                    $display("FAIL b2b_beat%0d: got %h want %h", i, beats[base+i],
                             {(i % 2 == 1), d[i]}); end
                if (i > 0) begin
                    gap = beat_cyc[base+i] - beat_cyc[base+i-1];
                    checks++;
                    if ((i % 2 == 1 && gap != 1) || (i % 2 == 0 && gap > 2)) begin errors++;
                        $display("FAIL b2b_gap%0d: got %0d want %0s", i, gap,
                                 (i % 2 == 1) ? "1" : "<=2"); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] a[7];
        int base, rd0;
        bit ok;
        burst_len = 5'd4;
        repeat (3) tick();
        rd0  = rd_cnt;
        base = beats.size();
        for (int i = 0; i < 7; i++) a[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) push(a[i]);
        wait_beats(base, 1, 20, ok);
        checks++; if (!ok || axis.M_AXIS_TVALID !== 1'b1 || axis.M_AXIS_TDATA !== a[1]) begin
            errors++;
            $display("FAIL rstm_pre: tvalid %b data %h want 1/%h", axis.M_AXIS_TVALID,
                     axis.M_AXIS_TDATA, a[1]); end
        #2 i_reset = 1'b1;
        #1;
        checks++; if (axis.M_AXIS_TVALID !== 1'b0 || axis.M_AXIS_TLAST !== 1'b0) begin
            errors++;
            $display("FAIL rstm_stream: tvalid %b tlast %b want 0/0", axis.M_AXIS_TVALID,
                     axis.M_AXIS_TLAST); end
        checks++; if (o_busy !== 1'b0 || o_threshold !== 5'd1) begin errors++;
            $display("FAIL rstm_ctrl: busy %b threshold %0d want 0/1", o_busy, o_threshold); end
        checks++; if (rd_cnt - rd0 != 2 || fcnt !== 5'd2) begin errors++;
            $display("FAIL rstm_reads: reads %0d fill %0d want 2/2", rd_cnt - rd0, fcnt); end
        tick();
        tick();
        i_reset = 1'b0;
        checks++; if (beats.size() != base + 1) begin errors++;
            $display("FAIL rstm_no_beats: got %0d want 1", beats.size() - base); end
        // Threshold restarts at 1, so the first word left in the FIFO goes alone.
        base = beats.size();
        wait_beats(base, 1, 20, ok);
        checks++; if (!ok || beats[base] !== {1'b1, a[2]}) begin errors++;
            $display("FAIL rstm_first: got %h want %h", ok ? beats[base] : 9'h0,
                     {1'b1, a[2]}); end
        repeat (5) tick();
        checks++; if (beats.size() != base + 1) begin errors++;
            $display("FAIL rstm_wait: got %0d beats want 1", beats.size() - base); end
        for (int i = 4; i < 7; i++) push(a[i]);
        wait_beats(base + 1, 4, 30, ok);
        checks++; if (!ok) begin errors++;
            $display("FAIL rstm_timeout: beats %0d want 5", beats.size() - base); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beats[base+1+i] !== {(i == 3), a[3+i]}) begin errors++;
                    $display("FAIL rstm_beat%0d: got %h want %h", i, beats[base+1+i],
                             {(i == 3), a[3+i]}); end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int base, len_raw, eff, n;
        bit ok;
        rand_ready = 1'b1;
        timeout    = 16'd0;
        for (int it = 0; it < 6; it++) begin
            len_raw   = $urandom_range(0, 31);
            eff       = (len_raw == 0) ? 1 : ((len_raw > 16) ? 16 : len_raw);
            burst_len = 5'(len_raw);
            repeat (3) tick();
            checks++; if (o_threshold !== 5'(eff)) begin errors++;
                $display("FAIL rnd%0d_threshold: got %0d want %0d", it, o_threshold, eff); end
            n    = eff * $urandom_range(1, 3);
            base = beats.size();
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(8'($urandom));
                push(exp_q[i]);
                if ($urandom_range(0, 3) == 0) tick();
            end
            wait_beats(base, n, 2000, ok);
            checks++; if (!ok) begin errors++;
                $display("FAIL rnd%0d_timeout: beats %0d want %0d", it, beats.size() - base, n);
            end
            if (ok) begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (beats[base+i] !== {(i % eff == eff - 1), exp_q[i]}) begin errors++;
                        $display("FAIL rnd%0d_beat%0d: got %h want %h", it, i, beats[base+i],
                                 {(i % eff == eff - 1), exp_q[i]}); end
                end
            end
        end
        rand_ready = 1'b0;
        axis.M_AXIS_TREADY = 1'b1;
        checks++; if (underflow != 0) begin errors++;
            $display("FAIL fifo_underflow: got %0d reads of empty FIFO want 0", underflow); end
    endtask

    initial begin
        axis.M_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge i_clk);
        test_reset();
        test_full_burst();
        test_backpressure();
        test_flush();
        test_clamp();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
